// File: rtl/spn_encipher_core.sv
// spn_encipher_core: iterative SPN block encipher core that shares one external, handshaked S-box word port.
// Optional feature: define ENC_ABORT_EN to add the abort input that cancels a running operation.
module spn_encipher_core #(
    parameter int unsigned       CELL_W   = 8,
    parameter logic [CELL_W-1:0] POLY     = CELL_W'(8'h1B),
    parameter int unsigned       NR_SHORT = 10,
    parameter int unsigned       NR_LONG  = 14,
    localparam int unsigned      WW       = 4 * CELL_W,
    localparam int unsigned      BW       = 16 * CELL_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          next,
    input  logic          keylen,
    input  logic [BW-1:0] block,
    output logic [3:0]    round,
    input  logic [BW-1:0] round_key,
    output logic [WW-1:0] sboxw,
    output logic          sbox_req,
    input  logic [WW-1:0] new_sboxw,
    input  logic          sbox_ack,
    output logic [BW-1:0] new_block,
    output logic          ready,
`ifdef ENC_ABORT_EN
    input  logic          abort,
`endif
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_SBOX = 2'd2,
        S_MAIN = 2'd3
    } state_e;

    typedef logic [15:0][CELL_W-1:0] cells_t;
    typedef logic [3:0][WW-1:0]      words_t;
    typedef logic [3:0][CELL_W-1:0]  col_t;

    localparam logic [3:0] NR_S = 4'(NR_SHORT);
    localparam logic [3:0] NR_L = 4'(NR_LONG);

    // Multiply by x in GF(2^CELL_W)
    function automatic logic [CELL_W-1:0] xtime(input logic [CELL_W-1:0] c);
        return {c[CELL_W-2:0], 1'b0} ^ (c[CELL_W-1] ? POLY : '0);
    endfunction

    // Circulant [2 3 1 1] applied to one column; cell 0 sits in the MSBs
    function automatic logic [WW-1:0] mix_word(input logic [WW-1:0] w);
        col_t a;
        col_t b;
        a = w;
        b = '0;
        for (int r = 0; r < 4; r++) begin
            b[3-r] = xtime(a[3-r]) ^ xtime(a[3-((r+1)%4)]) ^ a[3-((r+1)%4)]
                   ^ a[3-((r+2)%4)] ^ a[3-((r+3)%4)];
        end
        return b;
    endfunction

    function automatic logic [BW-1:0] mix_columns(input logic [BW-1:0] s);
        words_t a;
        words_t b;
        a = s;
        b = '0;
        for (int c = 0; c < 4; c++) begin
            b[c] = mix_word(a[c]);
        end
        return b;
    endfunction

    // Row r of the column-major state rotates left by r columns
    function automatic logic [BW-1:0] shift_rows(input logic [BW-1:0] s);
        cells_t a;
        cells_t b;
        a = s;
        b = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b[15-(4*c+r)] = a[15-(4*((c+r)%4)+r)];
            end
        end
        return b;
    endfunction

    state_e        state_q, state_d;
    logic [3:0]    round_q, round_d;
    logic [1:0]    wctr_q, wctr_d;
    logic          nr_sel_q, nr_sel_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          sbox_req_q, sbox_req_d;
    logic [WW-1:0] sboxw_q, sboxw_d;

    logic [3:0]    nr_c;
    words_t        upd_words;
    words_t        nxt_words;

    assign nr_c = nr_sel_q ? NR_L : NR_S;

    // Next-state, datapath and registered S-box request
    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        wctr_d     = wctr_q;
        nr_sel_d   = nr_sel_q;
        blk_d      = blk_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        upd_words  = blk_q;
        nxt_words  = '0;
        sbox_req_d = 1'b0;
        sboxw_d    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (next) begin
                    ready_d  = 1'b0;
                    round_d  = 4'd0;
                    nr_sel_d = keylen;
                    state_d  = S_INIT;
                end
            end
            S_INIT: begin
                blk_d   = block ^ round_key;
                round_d = round_q + 4'd1;
                wctr_d  = 2'd0;
                state_d = S_SBOX;
            end
            S_SBOX: begin
                if (sbox_ack) begin
                    upd_words[2'd3 - wctr_q] = new_sboxw;
                    blk_d  = upd_words;
                    wctr_d = wctr_q + 2'd1;
                    if (wctr_q == 2'd3) begin
                        state_d = S_MAIN;
                    end
                end
            end
            S_MAIN: begin
                if (round_q < nr_c) begin
                    blk_d   = mix_columns(shift_rows(blk_q)) ^ round_key;
                    round_d = round_q + 4'd1;
                    state_d = S_SBOX;
                end else begin
                    blk_d   = shift_rows(blk_q) ^ round_key;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef ENC_ABORT_EN
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            blk_d   = '0;
            round_d = 4'd0;
            wctr_d  = 2'd0;
            ready_d = 1'b1;
            done_d  = 1'b0;
        end
`endif

        // S-box port is registered from next-cycle state so it is glitch-free
        nxt_words  = blk_d;
        sbox_req_d = (state_d == S_SBOX);
        sboxw_d    = sbox_req_d ? nxt_words[2'd3 - wctr_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            round_q    <= 4'd0;
            wctr_q     <= 2'd0;
            nr_sel_q   <= 1'b0;
            blk_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            sbox_req_q <= 1'b0;
            sboxw_q    <= '0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            wctr_q     <= wctr_d;
            nr_sel_q   <= nr_sel_d;
            blk_q      <= blk_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            sbox_req_q <= sbox_req_d;
            sboxw_q    <= sboxw_d;
        end
    end

    assign round     = round_q;
    assign sboxw     = sboxw_q;
    assign sbox_req  = sbox_req_q;
    assign new_block = blk_q;
    assign ready     = ready_q;
    assign done      = done_q;

endmodule
